// File: rtl/spi_mnrch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_mnrch
// SPI monarch (master) for 16-bit full-duplex transfers with the iNEMO inertial
// sensor. A one-cycle wrt pulse launches a transfer. wt_data is shifted out on
// MOSI, MSB first, and MISO is shifted in at the same time. The received word
// ends up in rd_data.
//
// Ports
//   clk      in   system clock (50 MHz)
//   rst      in   synchronous active-high reset
//   wrt      in   1-cycle start pulse; ignored while a transfer is running
//   wt_data  in   [15:0] word to send, captured on the accepted wrt cycle
//   MISO     in   serial data from the serf
//   SS_n     out  serf select, low for the whole transfer
//   SCLK     out  serial clock, clk/16 while active, high when idle
//   MOSI     out  serial data to the serf (shift register MSB)
//   done     out  high from end of transfer until the next accepted wrt
//   rd_data  out  [15:0] received word, valid while done is high
// -----------------------------------------------------------------------------
module spi_mnrch (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // The divider idles at 1011. SCLK is therefore high, and the first fall
  // (1111 -> 0000) comes 5 clocks after the start.
  localparam logic [3:0] DIV_IDLE = 4'b1011;
  // Sample point: the cycle just before SCLK rises.
  localparam logic [3:0] DIV_SMPL = 4'b0111;
  // Shift point: the cycle where SCLK falls.
  localparam logic [3:0] DIV_FALL = 4'b1111;

  state_t      state_q,     state_d;
  logic [3:0]  sclk_div_q,  sclk_div_d;
  logic [15:0] shift_q,     shift_d;
  logic [3:0]  bit_cnt_q,   bit_cnt_d;
  logic        miso_smpl_q, miso_smpl_d;
  logic        ss_n_q,      ss_n_d;
  logic        done_q,      done_d;

  logic        at_fall;
  logic        at_smpl;

  assign at_fall = (sclk_div_q == DIV_FALL);
  assign at_smpl = (sclk_div_q == DIV_SMPL);

  always_comb begin
    state_d     = state_q;
    sclk_div_d  = sclk_div_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    miso_smpl_d = miso_smpl_q;
    ss_n_d      = ss_n_q;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        sclk_div_d = DIV_IDLE;
        if (wrt) begin
          shift_d   = wt_data;
          ss_n_d    = 1'b0;
          done_d    = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = FRONT;
        end
      end

      FRONT: begin
        sclk_div_d = sclk_div_q + 4'd1;
        // The first SCLK fall only frames the transfer. No data moves here.
        if (at_fall) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sclk_div_d = sclk_div_q + 4'd1;
        if (at_smpl) begin
          miso_smpl_d = MISO;
        end
        if (at_fall) begin
          shift_d   = {shift_q[14:0], miso_smpl_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // The last shift ends the transfer. Reloading the divider keeps
          // SCLK high, so no 17th falling edge is produced.
          if (bit_cnt_q == 4'd15) begin
            ss_n_d     = 1'b1;
            done_d     = 1'b1;
            sclk_div_d = DIV_IDLE;
            state_d    = IDLE;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        sclk_div_d = DIV_IDLE;
        ss_n_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_div_q  <= DIV_IDLE;
      shift_q     <= 16'h0000;
      bit_cnt_q   <= 4'd0;
      miso_smpl_q <= 1'b0;
      ss_n_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_div_q  <= sclk_div_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_smpl_q <= miso_smpl_d;
      ss_n_q      <= ss_n_d;
      done_q      <= done_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_div_q[3];
  assign MOSI    = shift_q[15];
  assign done    = done_q;
  assign rd_data = shift_q;

`ifndef SYNTHESIS
  // Select is deasserted exactly when the machine is idle, and the idle
  // divider value is what keeps SCLK parked high.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      assert (ss_n_q == (state_q == IDLE));
      assert ((state_q != IDLE) || (sclk_div_q == DIV_IDLE));
    end
  end
`endif

endmodule

// File: tb/tb_spi_mnrch.sv
`timescale 1ns/1ps
module tb_spi_mnrch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrt = 1'b0;
  logic [15:0] wt_data = 16'h0000;
  logic        MISO;
  logic        SS_n, SCLK, MOSI, done;
  logic [15:0] rd_data;

  always #10 clk = ~clk;

  spi_mnrch dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .wt_data (wt_data),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .done    (done),
    .rd_data (rd_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Golden sensor bytes for register a (0x22..0x2B) of sample sp.
  function automatic logic [7:0] golden(input int sp, input logic [6:0] a);
    return 8'(int'(a) * 7 + sp * 13 + 'h31);
  endfunction

  function automatic logic [7:0] serf_reg(input logic [6:0] a, input int sp);
    if (a == 7'h0F) return 8'h6A;
    if (a >= 7'h22 && a <= 7'h2B) return golden(sp, a);
    return 8'h00;
  endfunction

  // ---------------- iNEMO serf model ----------------
  logic        loopback = 1'b0;
  logic        s_miso   = 1'b0;
  logic        ss_prev  = 1'b1;
  logic        sclk_prev = 1'b1;
  int          s_cnt = 0;
  logic [15:0] s_rx = 16'h0000;
  logic [15:0] s_tx = 16'h0000;
  int          samp = 0;
  logic        int_en = 1'b0;
  int          last2b = 0;
  logic        INT;

  assign MISO = loopback ? MOSI : s_miso;
  assign INT  = int_en && ((cyc - last2b) > 40);

  always @(SS_n or SCLK) begin
    if (ss_prev === 1'b1 && SS_n === 1'b0) begin
      s_cnt = 0; s_rx = 16'h0000; s_tx = 16'h0000; s_miso = 1'b0;
    end else if (SS_n === 1'b0 && sclk_prev === 1'b0 && SCLK === 1'b1) begin
      s_rx  = {s_rx[14:0], MOSI};
      s_cnt = s_cnt + 1;
      if (s_cnt == 8 && s_rx[7]) s_tx[7:0] = serf_reg(s_rx[6:0], samp);
      if (s_cnt == 16) begin
        if (!s_rx[15] && s_rx[14:8] == 7'h0D) int_en = s_rx[1];
        if (s_rx[15] && s_rx[14:8] == 7'h2B) begin
          samp   = samp + 1;
          last2b = cyc;
        end
      end
    end else if (SS_n === 1'b0 && sclk_prev === 1'b1 && SCLK === 1'b0) begin
      if (s_cnt >= 1 && s_cnt <= 15) s_miso = s_tx[15 - s_cnt];
    end
    ss_prev   = SS_n;
    sclk_prev = SCLK;
  end

  // ---------------- transaction-level model ----------------
  // A transfer lasts 261 clocks after acceptance. SCLK follows the divider
  // phase (11+k) mod 16. Shifts land at k = 5+16j, and the outputs are
  // derived from the sent and expected-received words.
  logic        m_ok = 1'b0, m_act = 1'b0, m_done = 1'b0;
  int          m_k = 0;
  logic [15:0] m_word = 16'h0, m_rx = 16'h0, m_rd = 16'h0;
  logic [15:0] next_rx = 16'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_ok   <= 1'b1;
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_rd   <= 16'h0000;
    end else if (m_act) begin
      if (m_k == 260) begin
        m_act  <= 1'b0;
        m_done <= 1'b1;
        m_rd   <= m_rx;
      end else begin
        m_k <= m_k + 1;
      end
    end else if (wrt) begin
      m_act  <= 1'b1;
      m_k    <= 0;
      m_word <= wt_data;
      m_rx   <= next_rx;
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  int rises = 0;
  int last_rise = -1;

  task automatic start(input logic [15:0] w, input logic [15:0] rx);
    @(negedge clk);
    wt_data   = w;
    next_rx   = rx;
    wrt       = 1'b1;
    rises     = 0;
    last_rise = -1;
    @(posedge clk);
    #1 wrt = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int waited;
    logic [7:0] g;

    fork
      begin : cmp
        logic [31:0] cat;
        logic [15:0] er;
        logic [19:0] exp_v, act_v;
        int s;
        forever begin
          @(negedge clk);
          if (m_ok) begin
            if (m_act) begin
              s     = (m_k >= 21) ? (m_k - 5) / 16 : 0;
              cat   = {m_word, m_rx} << s;
              er    = cat[31:16];
              exp_v = {1'b0, (((11 + m_k) % 16) >= 8), 1'b0, er[15], er};
            end else begin
              exp_v = {1'b1, 1'b1, m_done, m_rd[15], m_rd};
            end
            act_v = {SS_n, SCLK, done, MOSI, rd_data};
            chk($sformatf("cycle k=%0d act=%0d", m_k, m_act), 32'(act_v), 32'(exp_v));
          end
        end
      end
      begin : sclk_mon
        forever begin
          @(posedge SCLK);
          if (SS_n === 1'b0) begin
            rises = rises + 1;
            if (last_rise >= 0) chk("sclk_period", 32'(cyc - last_rise), 32'd16);
            last_rise = cyc;
          end
        end
      end
      begin : mosi_mon
        forever begin
          @(MOSI);
          if (m_act && m_k > 0 && SS_n === 1'b0) chk("mosi_on_fall", 32'(SCLK), 32'd0);
        end
      end
    join_none

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_SS_n", 32'(SS_n), 32'd1);
    chk("rst_SCLK", 32'(SCLK), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);

    // 1. Loopback
    loopback = 1'b1;
    start(16'hA5C3, 16'hA5C3);
    wait_done(lat);
    chk("lb_latency", 32'(lat), 32'd261);
    chk("lb_rd_data", 32'(rd_data), 32'hA5C3);
    chk("lb_rises", 32'(rises), 32'd16);

    // 2. WHO_AM_I
    loopback = 1'b0;
    start(16'h8F00, 16'h006A);
    wait_done(lat);
    chk("who_am_i", 32'(rd_data[7:0]), 32'h6A);
    chk("who_rises", 32'(rises), 32'd16);

    // 3. Enable data-ready INT, then register reads for a few samples
    start(16'h0D02, 16'h0000);
    wait_done(lat);
    for (int sp = 0; sp < 3; sp++) begin
      waited = 0;
      while (INT !== 1'b1 && waited < 40000) begin
        @(posedge clk);
        #1;
        waited++;
      end
      chk("int_seen", 32'(INT), 32'd1);
      for (int a = 'h22; a <= 'h2B; a++) begin
        g = golden(sp, 7'(a));
        start({8'h80 | 8'(a), 8'h00}, {8'h00, g});
        wait_done(lat);
        chk($sformatf("reg_read s%0d a%0h", sp, a), 32'(rd_data[7:0]), 32'(g));
        if (sp == 0 && a == 'h22) chk("pitch0_literal", 32'(rd_data[7:0]), 32'h1F);
      end
    end

    // 4. wrt during SHIFT is ignored
    loopback = 1'b1;
    start(16'h1234, 16'h1234);
    repeat (100) @(posedge clk);
    @(negedge clk);
    wt_data = 16'hFFFF;
    next_rx = 16'hFFFF;
    wrt     = 1'b1;
    @(posedge clk);
    #1 wrt = 1'b0;
    wait_done(lat);
    chk("midshift_rd_data", 32'(rd_data), 32'h1234);
    chk("midshift_rises", 32'(rises), 32'd16);

    // 5. Reset mid-transfer, then a normal transfer
    start(16'hBEEF, 16'hBEEF);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_SS_n", 32'(SS_n), 32'd1);
    chk("midrst_SCLK", 32'(SCLK), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    start(16'h5A5A, 16'h5A5A);
    wait_done(lat);
    chk("post_rst_latency", 32'(lat), 32'd261);
    chk("post_rst_rd_data", 32'(rd_data), 32'h5A5A);
    chk("post_rst_rises", 32'(rises), 32'd16);

    // 6. SCLK parked high while idle
    repeat (20) @(negedge clk);
    chk("idle_SCLK", 32'(SCLK), 32'd1);
    chk("idle_done_held", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
